mem_port_arbiter: RTL and testbench

Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the five-stage RISC-V pipeline. It serialises the two requesters through a registered grant FSM and drives the memory-side request/acknowledge handshake. It returns read data per requester and raises per-requester stall signals that feed the hazard unit as extra StallF/StallD/StallE/StallM causes.

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/mem_arb_starve_ctr.sv | 28 ++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared pipeline types for the memory-port arbiter.
// Holds the grant FSM state encoding and the latched memory request.
package riscv_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_BE_W   = ARB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    DM_WAIT = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [ARB_BE_W-1:0]   be;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } mem_req_t;

  // Instruction fetches are always full-word reads.
  function automatic mem_req_t fetch_req(input logic [ARB_ADDR_W-1:0] addr);
    mem_req_t req;
    req.we    = 1'b0;
    req.be    = '1;
    req.addr  = addr;
    req.wdata = '0;
    return req;
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive data grants while a fetch is waiting and raises
// o_forceFetch once STARVE_MAX of them have gone by.
module mem_arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ifReq,
  input  logic i_dmGrant,
  input  logic i_ifGrant,
  output logic o_forceFetch
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_ifGrant || !i_ifReq) begin
      r_count <= '0;
    end else if (i_dmGrant && !o_forceFetch) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_forceFetch = (r_count == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data accesses onto one single-ported memory.
// Define ARB_ANTI_STARVE_EN to bound consecutive data grants while a fetch waits.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_valid,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [DATA_W/8-1:0]   dm_be,
  input  logic [ADDR_W-1:0]     dm_addr,
  input  logic [DATA_W-1:0]     dm_wdata,
  output logic [DATA_W-1:0]     dm_rdata,
  output logic                  dm_valid,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  stall_if,
  output logic                  stall_dm
);

  arb_state_t        r_state;
  arb_state_t        w_nextState;
  mem_req_t          r_grant;
  logic              r_memReq;
  logic              r_servedDm;
  logic [DATA_W-1:0] r_ifRdata;
  logic [DATA_W-1:0] r_dmRdata;
  logic              w_grantIf;
  logic              w_grantDm;
  logic              w_forceFetch;
  logic              w_ack;

`ifdef ARB_ANTI_STARVE_EN
  mem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starveCtr (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ifReq     (if_req),
    .i_dmGrant   (w_grantDm),
    .i_ifGrant   (w_grantIf),
    .o_forceFetch(w_forceFetch)
  );
`else
  logic w_unusedStarveMax;
  assign w_unusedStarveMax = (STARVE_MAX != 0);
  assign w_forceFetch      = 1'b0;
`endif

  // An ack only counts while a granted access is outstanding.
  assign w_ack = mem_ack && ((r_state == IF_WAIT) || (r_state == DM_WAIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_grantIf   = 1'b0;
    w_grantDm   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (if_req && (w_forceFetch || !dm_req)) begin
          w_nextState = IF_WAIT;
          w_grantIf   = 1'b1;
        end else if (dm_req) begin
          w_nextState = DM_WAIT;
          w_grantDm   = 1'b1;
        end
      end
      IF_WAIT, DM_WAIT: begin
        if (mem_ack) w_nextState = RESP;
      end
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Grant fields stay frozen from grant to the next grant so memory sees a stable request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_memReq   <= 1'b0;
      r_servedDm <= 1'b0;
      r_grant    <= '0;
      r_ifRdata  <= '0;
      r_dmRdata  <= '0;
    end else if (w_grantDm) begin
      r_memReq   <= 1'b1;
      r_servedDm <= 1'b1;
      r_grant    <= '{we: dm_we, be: dm_be, addr: dm_addr, wdata: dm_wdata};
    end else if (w_grantIf) begin
      r_memReq   <= 1'b1;
      r_servedDm <= 1'b0;
      r_grant    <= fetch_req(if_addr);
    end else if (w_ack) begin
      r_memReq <= 1'b0;
      if (r_state == IF_WAIT) begin
        r_ifRdata <= mem_rdata;
      end else if (!r_grant.we) begin
        r_dmRdata <= mem_rdata;
      end
    end
  end

  assign mem_req   = r_memReq;
  assign mem_we    = r_grant.we;
  assign mem_be    = r_grant.be;
  assign mem_addr  = r_grant.addr;
  assign mem_wdata = r_grant.wdata;

  assign if_rdata  = r_ifRdata;
  assign dm_rdata  = r_dmRdata;
  assign if_valid  = (r_state == RESP) && !r_servedDm;
  assign dm_valid  = (r_state == RESP) && r_servedDm;

  assign stall_if  = if_req && !if_valid;
  assign stall_dm  = dm_req && !dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a latency-programmable memory.
// Back-to-back expectations follow ARB_ANTI_STARVE_EN when it is defined for the build.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_dm;

  int          errors;
  int          checks;
  int          memLat;
  int          memCnt;
  logic        forceAck;
  logic [31:0] expDmRdata;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_MAX(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_be    (dm_be),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_valid (dm_valid),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_be   (mem_be),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .stall_if (stall_if),
    .stall_dm (stall_dm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0051_0513;
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory acks memLat cycles after mem_req rises; read data is junk outside the ack cycle.
  always @(posedge clk) begin
    #1;
    if (mem_req === 1'b1) begin
      mem_ack = (memCnt == memLat) || forceAck;
      memCnt  = memCnt + 1;
    end else begin
      mem_ack = forceAck;
      memCnt  = 0;
    end
    mem_rdata = mem_ack ? memWord(mem_addr) : 32'h0BAD_0BAD;
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) nextCycle();
    @(negedge clk);
    checks++;
    if ({mem_req, if_valid, dm_valid} !== 3'b000)
      $display("[TB] FAIL reset_ctrl: got %b expected 000", {mem_req, if_valid, dm_valid});
    if ({mem_req, if_valid, dm_valid} !== 3'b000) errors++;
    checks++;
    if ({mem_we, mem_be, mem_addr, mem_wdata} !== 69'd0) begin
      errors++;
      $display("[TB] FAIL reset_memfields: got we=%b be=%b addr=%h wdata=%h expected all zero",
               mem_we, mem_be, mem_addr, mem_wdata);
    end
    checks++;
    if ({if_rdata, dm_rdata} !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_rdata: got if=%h dm=%h expected 0", if_rdata, dm_rdata);
    end
    nextCycle();
    rst = 1'b0;
    nextCycle();
  endtask

  task automatic test_fetch_only();
    logic [2:0] expV;
    memLat  = 2;
    if_addr = 32'h0000_0010;
    if_req  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      expV = {c == 4, c <= 3, (c >= 1) && (c <= 3)};
      checks++;
      if ({if_valid, stall_if, mem_req} !== expV) begin
        errors++;
        $display("[TB] FAIL fetch_c%0d valid/stall/req: got %b expected %b", c,
                 {if_valid, stall_if, mem_req}, expV);
      end
      if (c == 1) begin
        checks++;
        if ({mem_we, mem_be, mem_addr} !== {1'b0, 4'hF, 32'h0000_0010}) begin
          errors++;
          $display("[TB] FAIL fetch_memfields: got we=%b be=%b addr=%h expected 0/1111/00000010",
                   mem_we, mem_be, mem_addr);
        end
      end
      if (c == 4) begin
        checks++;
        if (if_rdata !== 32'h0051_0513) begin
          errors++;
          $display("[TB] FAIL fetch_rdata: got %h expected 00510513", if_rdata);
        end
      end
      nextCycle();
      if (c == 4) if_req = 1'b0;
    end
  endtask

  task automatic test_store();
    logic [2:0] expV;
    memLat   = 0;
    dm_we    = 1'b1;
    dm_be    = 4'b0011;
    dm_addr  = 32'h0000_0100;
    dm_wdata = 32'hDEAD_BEEF;
    dm_req   = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      expV = {c == 2, c <= 1, c == 1};
      checks++;
      if ({dm_valid, stall_dm, mem_req} !== expV) begin
        errors++;
        $display("[TB] FAIL store_c%0d valid/stall/req: got %b expected %b", c,
                 {dm_valid, stall_dm, mem_req}, expV);
      end
      if (c == 1) begin
        checks++;
        if ({mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF}) begin
          errors++;
          $display("[TB] FAIL store_memfields: got we=%b be=%b addr=%h wdata=%h expected 1/0011/00000100/deadbeef",
                   mem_we, mem_be, mem_addr, mem_wdata);
        end
      end
      if (c == 2) begin
        checks++;
        if (dm_rdata !== expDmRdata) begin
          errors++;
          $display("[TB] FAIL store_rdata_kept: got %h expected %h", dm_rdata, expDmRdata);
        end
      end
      nextCycle();
      if (c == 2) begin
        dm_req = 1'b0;
        dm_we  = 1'b0;
      end
    end
  endtask

  task automatic test_load();
    logic [2:0] expV;
    memLat  = 1;
    dm_we   = 1'b0;
    dm_be   = 4'hF;
    dm_addr = 32'h0000_0200;
    dm_req  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      expV = {c == 3, c <= 2, (c >= 1) && (c <= 2)};
      checks++;
      if ({dm_valid, stall_dm, mem_req} !== expV) begin
        errors++;
        $display("[TB] FAIL load_c%0d valid/stall/req: got %b expected %b", c,
                 {dm_valid, stall_dm, mem_req}, expV);
      end
      if (c == 3) begin
        checks++;
        if (dm_rdata !== 32'hC0DE_0200) begin
          errors++;
          $display("[TB] FAIL load_rdata: got %h expected c0de0200", dm_rdata);
        end
        expDmRdata = 32'hC0DE_0200;
      end
      nextCycle();
      if (c == 3) dm_req = 1'b0;
    end
  endtask

  task automatic test_idle_ack();
    @(negedge clk);
    forceAck = 1'b1;
    for (int c = 0; c < 2; c++) begin
      nextCycle();
      @(negedge clk);
      checks++;
      if ({if_valid, dm_valid, mem_req} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL idle_ack_c%0d: got %b expected 000", c, {if_valid, dm_valid, mem_req});
      end
    end
    forceAck = 1'b0;
    checks++;
    if ({if_rdata, dm_rdata} !== {32'h0051_0513, expDmRdata}) begin
      errors++;
      $display("[TB] FAIL idle_ack_rdata: got if=%h dm=%h expected 00510513/%h",
               if_rdata, dm_rdata, expDmRdata);
    end
    nextCycle();
    nextCycle();
  endtask

  task automatic test_collision();
    logic [4:0] expV;
    memLat  = 1;
    dm_we   = 1'b0;
    dm_be   = 4'b0000;
    dm_addr = 32'h0000_0300;
    if_addr = 32'h0000_0014;
    dm_req  = 1'b1;
    if_req  = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      expV = {c == 3, c == 7, (c == 1) || (c == 2) || (c == 5) || (c == 6), c <= 2, c <= 6};
      checks++;
      if ({dm_valid, if_valid, mem_req, stall_dm, stall_if} !== expV) begin
        errors++;
        $display("[TB] FAIL collide_c%0d dv/iv/req/sd/si: got %b expected %b", c,
                 {dm_valid, if_valid, mem_req, stall_dm, stall_if}, expV);
      end
      if (c == 1) begin
        checks++;
        if ({mem_we, mem_addr} !== {1'b0, 32'h0000_0300}) begin
          errors++;
          $display("[TB] FAIL collide_dm_grant: got we=%b addr=%h expected 0/00000300", mem_we, mem_addr);
        end
      end
      if (c == 3) begin
        checks++;
        if (dm_rdata !== 32'hC0DE_0300) begin
          errors++;
          $display("[TB] FAIL collide_dm_rdata: got %h expected c0de0300", dm_rdata);
        end
        expDmRdata = 32'hC0DE_0300;
      end
      if (c == 5) begin
        checks++;
        if ({mem_we, mem_be, mem_addr} !== {1'b0, 4'hF, 32'h0000_0014}) begin
          errors++;
          $display("[TB] FAIL collide_if_grant: got we=%b be=%b addr=%h expected 0/1111/00000014",
                   mem_we, mem_be, mem_addr);
        end
      end
      if (c == 7) begin
        checks++;
        if (if_rdata !== 32'hC0DE_0014) begin
          errors++;
          $display("[TB] FAIL collide_if_rdata: got %h expected c0de0014", if_rdata);
        end
      end
      nextCycle();
      if (c == 3) dm_req = 1'b0;
      if (c == 7) if_req = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int          dmServed;
    int          ifAfter;
    int          cyc;
    int          expIfAfter;
    logic        dataOk;
    logic        overlap;
    logic        sawDm;
    logic        sawIf;
    logic [31:0] curAddr;
`ifdef ARB_ANTI_STARVE_EN
    expIfAfter = 4;
`else
    expIfAfter = 6;
`endif
    dmServed = 0;
    ifAfter  = -1;
    cyc      = 0;
    dataOk   = 1'b1;
    overlap  = 1'b0;
    curAddr  = 32'h0000_0400;
    memLat   = 0;
    dm_we    = 1'b0;
    dm_be    = 4'hF;
    dm_addr  = curAddr;
    if_addr  = 32'h0000_0018;
    dm_req   = 1'b1;
    if_req   = 1'b1;
    while (((dmServed < 6) || (ifAfter < 0)) && (cyc < 80)) begin
      @(negedge clk);
      sawDm = dm_valid;
      sawIf = if_valid;
      if (sawDm && sawIf) overlap = 1'b1;
      if (sawDm) begin
        if (dm_rdata !== (curAddr ^ 32'hC0DE_0000)) dataOk = 1'b0;
        expDmRdata = curAddr ^ 32'hC0DE_0000;
        dmServed++;
      end
      if (sawIf) begin
        if (if_rdata !== 32'hC0DE_0018) dataOk = 1'b0;
        ifAfter = dmServed;
      end
      nextCycle();
      cyc++;
      if (sawDm) begin
        if (dmServed < 6) begin
          curAddr = curAddr + 32'd4;
          dm_addr = curAddr;
        end else begin
          dm_req = 1'b0;
        end
      end
      if (sawIf) if_req = 1'b0;
    end
    checks++;
    if ((dmServed != 6) || (ifAfter < 0)) begin
      errors++;
      $display("[TB] FAIL b2b_timeout: got dm=%0d if_after=%0d after %0d cycles expected dm=6 and a fetch",
               dmServed, ifAfter, cyc);
    end
    checks++;
    if (ifAfter != expIfAfter) begin
      errors++;
      $display("[TB] FAIL b2b_fetch_slot: got fetch after %0d data grants expected %0d", ifAfter, expIfAfter);
    end
    checks++;
    if (!dataOk) begin
      errors++;
      $display("[TB] FAIL b2b_rdata: got wrong read data expected addr^c0de0000 per load and c0de0018 for fetch");
    end
    checks++;
    if (overlap) begin
      errors++;
      $display("[TB] FAIL b2b_overlap: got if_valid and dm_valid together expected never");
    end
    dm_req = 1'b0;
    if_req = 1'b0;
    nextCycle();
    nextCycle();
  endtask

  task automatic test_reset_mid();
    logic [1:0] expV;
    memLat  = 10;
    dm_we   = 1'b0;
    dm_be   = 4'hF;
    dm_addr = 32'h0000_0500;
    dm_req  = 1'b1;
    nextCycle();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rstmid_pending: got mem_req=%b expected 1", mem_req);
    end
    nextCycle();
    rst    = 1'b1;
    dm_req = 1'b0;
    nextCycle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, dm_valid, if_valid} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL rstmid_c%0d req/dv/iv: got %b expected 000", c, {mem_req, dm_valid, if_valid});
      end
      nextCycle();
    end
    checks++;
    if (dm_rdata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL rstmid_rdata: got %h expected 0", dm_rdata);
    end
    memLat  = 1;
    dm_addr = 32'h0000_0504;
    dm_req  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      expV = {c == 3, (c >= 1) && (c <= 2)};
      checks++;
      if ({dm_valid, mem_req} !== expV) begin
        errors++;
        $display("[TB] FAIL rstmid_new_c%0d valid/req: got %b expected %b", c, {dm_valid, mem_req}, expV);
      end
      if (c == 3) begin
        checks++;
        if (dm_rdata !== 32'hC0DE_0504) begin
          errors++;
          $display("[TB] FAIL rstmid_new_rdata: got %h expected c0de0504", dm_rdata);
        end
      end
      nextCycle();
      if (c == 3) dm_req = 1'b0;
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    memLat     = 0;
    memCnt     = 0;
    forceAck   = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    expDmRdata = 32'h0;
    rst        = 1'b1;
    if_req     = 1'b0;
    if_addr    = 32'h0;
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    dm_be      = 4'h0;
    dm_addr    = 32'h0;
    dm_wdata   = 32'h0;
    test_reset();
    test_fetch_only();
    test_store();
    test_load();
    test_idle_ack();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
